// File: rtl/nios2_button_ctrl.sv
// Avalon-MM push-button controller: 2-flop sync, per-bit debounce, edge capture (W1C), masked level IRQ.
// Latency: pin change to debounced level 2+DEBOUNCE_CYCLES cycles; capture one cycle later; readdata 1 cycle.
// Backpressure: none; slave is always ready (no waitrequest), reads return registered data one cycle later.
module nios2_button_ctrl #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port
);

  // Terminal count: a differing level must be seen this many extra cycles before acceptance
  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam int ADDR_DATA    = 0;
  localparam int ADDR_STATUS  = 1;
  localparam int ADDR_IRQMASK = 2;
  localparam int ADDR_EDGECAP = 3;

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;

  logic [WIDTH-1:0] w_busy;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd_mux;
  logic             w_wr;
  logic             w_unused_wdata;

  // Bits of writedata above WIDTH are architecturally ignored
  assign w_unused_wdata = ^writedata;

  assign w_wr = chipselect & ~write_n;

  // Two-flop synchroniser for the asynchronous pins; idle (released) level is all-ones
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= in_port;
      r_s2 <= r_s1;
    end
  end

  // Per-bit debounce: accept a new level only after it persists; any return to stable restarts the count
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stable <= '1;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LP_CNT_MAX) begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Busy flags: a bit is busy while its debounce counter is running
  always_comb begin
    w_busy = '0;
    for (int i = 0; i < WIDTH; i++) w_busy[i] = (r_cnt[i] != '0);
  end

  // Edge selection on the debounced level against its one-cycle delayed copy
  always_comb begin
    w_edge = '0;
    if (EDGE_TYPE == 0)      w_edge = r_stable_d & ~r_stable;
    else if (EDGE_TYPE == 1) w_edge = ~r_stable_d & r_stable;
    else                     w_edge = r_stable_d ^ r_stable;
  end

  // W1C clear vector from a write to EDGECAP
  always_comb begin
    w_clr = '0;
    if (w_wr && (address == 2'(ADDR_EDGECAP))) w_clr = writedata[WIDTH-1:0];
  end

  // Edge capture and delayed level; a new edge beats a simultaneous clear of the same bit
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stable_d <= '1;
      r_edge_cap <= '0;
    end else begin
      r_stable_d <= r_stable;
      r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
    end
  end

  // Interrupt mask register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_irq_mask <= '0;
    end else if (w_wr && (address == 2'(ADDR_IRQMASK))) begin
      r_irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // Read mux, zero-extended to the bus width
  always_comb begin
    w_rd_mux = '0;
    case (address)
      2'(ADDR_DATA):    w_rd_mux[WIDTH-1:0] = r_stable;
      2'(ADDR_STATUS):  w_rd_mux[WIDTH-1:0] = w_busy;
      2'(ADDR_IRQMASK): w_rd_mux[WIDTH-1:0] = r_irq_mask;
      default:          w_rd_mux[WIDTH-1:0] = r_edge_cap;
    endcase
  end

  // Registered read data, updated every cycle regardless of chipselect
  always_ff @(posedge clk) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= w_rd_mux;
  end

  assign irq = |(r_edge_cap & r_irq_mask);

endmodule
